// File: rtl/sensor_delta_monitor.sv
// Per-channel change detector: a sample commits as the channel's new value once
// CONFIRM consecutive samples on that channel differ from it by more than threshold.
module sensor_delta_monitor #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CONFIRM  = 2,
    parameter int CNTW     = 16,
    localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [CHW-1:0]      in_ch,
    input  logic [WIDTH-1:0]    in_data,
    input  logic [WIDTH-1:0]    threshold,
    input  logic                clear,
    output logic                q,
    output logic [CHW-1:0]      q_ch,
    output logic [WIDTH-1:0]    q_value,
    output logic [WIDTH-1:0]    q_delta,
    output logic [CHANNELS-1:0] sticky,
    output logic [CNTW-1:0]     evt_count
);

    logic [WIDTH-1:0]    stored_q [CHANNELS];
    logic [3:0]          confirm_q [CHANNELS];
    logic                q_q;
    logic [CHW-1:0]      q_ch_q;
    logic [WIDTH-1:0]    q_value_q;
    logic [WIDTH-1:0]    q_delta_q;
    logic [CHANNELS-1:0] sticky_q, sticky_d;
    logic [CNTW-1:0]     evt_q, evt_d;

    logic                ch_ok;
    logic                accept;
    logic                over;
    logic                hit;
    logic [CHW-1:0]      ch_idx;
    logic [WIDTH-1:0]    cur;
    logic [WIDTH-1:0]    delta;
    logic [3:0]          conf_inc;

    always_comb begin
        ch_ok    = 32'(in_ch) < CHANNELS;
        // Out-of-range channels are steered to index 0 but never accepted.
        ch_idx   = ch_ok ? in_ch : '0;
        accept   = in_valid && ch_ok;
        cur      = stored_q[ch_idx];
        delta    = (cur > in_data) ? (cur - in_data) : (in_data - cur);
        over     = delta > threshold;
        conf_inc = confirm_q[ch_idx] + 4'd1;
        hit      = accept && over && (conf_inc == 4'(CONFIRM));

        for (int i = 0; i < CHANNELS; i++) begin
            sticky_d[i] = (sticky_q[i] && !clear) || (hit && (ch_idx == CHW'(i)));
        end

        // A commit on the same edge as clear leaves exactly that one event counted.
        if (hit) begin
            if (clear)
                evt_d = CNTW'(1);
            else
                evt_d = (&evt_q) ? evt_q : evt_q + CNTW'(1);
        end else begin
            evt_d = clear ? '0 : evt_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                stored_q[i]  <= '0;
                confirm_q[i] <= '0;
            end
            q_q       <= 1'b0;
            q_ch_q    <= '0;
            q_value_q <= '0;
            q_delta_q <= '0;
            sticky_q  <= '0;
            evt_q     <= '0;
        end else begin
            q_q <= hit;
            if (hit) begin
                q_ch_q    <= ch_idx;
                q_value_q <= in_data;
                q_delta_q <= delta;
            end
            if (accept) begin
                if (!over) begin
                    confirm_q[ch_idx] <= '0;
                end else if (hit) begin
                    confirm_q[ch_idx] <= '0;
                    stored_q[ch_idx]  <= in_data;
                end else begin
                    confirm_q[ch_idx] <= conf_inc;
                end
            end
            sticky_q <= sticky_d;
            evt_q    <= evt_d;
        end
    end

    assign q         = q_q;
    assign q_ch      = q_ch_q;
    assign q_value   = q_value_q;
    assign q_delta   = q_delta_q;
    assign sticky    = sticky_q;
    assign evt_count = evt_q;

endmodule

// File: tb/tb_sensor_delta_monitor.sv
// Bench for sensor_delta_monitor: two builds (default, and 3-channel/CONFIRM=1/CNTW=2)
// driven with directed and random samples against a queue-based reference model.
module tb_sensor_delta_monitor;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       v_a = 0, clr_a = 0;
    logic [1:0] ch_a = 0;
    logic [7:0] d_a = 0, thr_a = 0;
    logic       q_a;
    logic [1:0] qch_a;
    logic [7:0] qv_a, qd_a;
    logic [3:0] st_a;
    logic [15:0] ev_a;

    logic       v_b = 0, clr_b = 0;
    logic [1:0] ch_b = 0;
    logic [7:0] d_b = 0, thr_b = 0;
    logic       q_b;
    logic [1:0] qch_b;
    logic [7:0] qv_b, qd_b;
    logic [2:0] st_b;
    logic [1:0] ev_b;

    sensor_delta_monitor dut_a (
        .clk(clk), .reset(reset), .in_valid(v_a), .in_ch(ch_a), .in_data(d_a),
        .threshold(thr_a), .clear(clr_a), .q(q_a), .q_ch(qch_a), .q_value(qv_a),
        .q_delta(qd_a), .sticky(st_a), .evt_count(ev_a)
    );

    sensor_delta_monitor #(.WIDTH(8), .CHANNELS(3), .CONFIRM(1), .CNTW(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(v_b), .in_ch(ch_b), .in_data(d_b),
        .threshold(thr_b), .clear(clr_b), .q(q_b), .q_ch(qch_b), .q_value(qv_b),
        .q_delta(qd_b), .sticky(st_b), .evt_count(ev_b)
    );

    typedef struct {int cyc; int ch; int val; int dlt;} rec_t;
    rec_t qa[$];
    rec_t qb[$];

    int nch[2]    = '{4, 3};
    int conf_n[2] = '{2, 1};
    int cmax[2]   = '{65535, 3};
    int m_st[2][16];
    int m_cf[2][16];
    int m_sticky[2], m_cnt[2], m_lch[2], m_lv[2], m_ld[2];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    bit mon_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 16; c++) begin
                m_st[i][c] = 0;
                m_cf[i][c] = 0;
            end
            m_sticky[i] = 0; m_cnt[i] = 0;
            m_lch[i] = 0; m_lv[i] = 0; m_ld[i] = 0;
        end
        qa.delete();
        qb.delete();
    endtask

    task automatic model_step(int i, bit v, int ch, int d, int thr, bit clr);
        int dl;
        rec_t r;
        if (clr) begin
            m_sticky[i] = 0;
            m_cnt[i] = 0;
        end
        if (!v || ch >= nch[i]) return;
        dl = (d > m_st[i][ch]) ? d - m_st[i][ch] : m_st[i][ch] - d;
        if (dl <= thr) begin
            m_cf[i][ch] = 0;
            return;
        end
        m_cf[i][ch]++;
        if (m_cf[i][ch] < conf_n[i]) return;
        m_cf[i][ch] = 0;
        m_st[i][ch] = d;
        m_sticky[i] |= (1 << ch);
        if (m_cnt[i] < cmax[i]) m_cnt[i]++;
        m_lch[i] = ch; m_lv[i] = d; m_ld[i] = dl;
        r = '{cyc, ch, d, dl};
        if (i == 0) qa.push_back(r); else qb.push_back(r);
    endtask

    task automatic drive(int i, bit v, int ch, int d, int thr, bit clr);
        @(negedge clk);
        if (i == 0) begin
            v_a = v; ch_a = 2'(ch); d_a = 8'(d); thr_a = 8'(thr); clr_a = clr;
        end else begin
            v_b = v; ch_b = 2'(ch); d_b = 8'(d); thr_b = 8'(thr); clr_b = clr;
        end
        @(posedge clk);
        #1;
        model_step(i, v, ch, d, thr, clr);
        v_a = 0; clr_a = 0; v_b = 0; clr_b = 0;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_q_a"}, q_a, 0);     chk({tag, "_qv_a"}, qv_a, 0);
        chk({tag, "_qd_a"}, qd_a, 0);   chk({tag, "_qch_a"}, qch_a, 0);
        chk({tag, "_st_a"}, st_a, 0);   chk({tag, "_ev_a"}, ev_a, 0);
        chk({tag, "_q_b"}, q_b, 0);     chk({tag, "_qv_b"}, qv_b, 0);
        chk({tag, "_st_b"}, st_b, 0);   chk({tag, "_ev_b"}, ev_b, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_zero("async_reset");
        model_reset();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic mon_inst(int i, string tag, int qv, int qch, int val, int dlt, int st, int ev);
        rec_t r;
        bit e;
        e = (i == 0) ? (qa.size() > 0 && qa[0].cyc <= cyc) : (qb.size() > 0 && qb[0].cyc <= cyc);
        chk({"q_pulse_", tag}, qv, int'(e));
        if (e) begin
            r = (i == 0) ? qa.pop_front() : qb.pop_front();
            chk({"commit_ch_", tag}, qch, r.ch);
            chk({"commit_value_", tag}, val, r.val);
            chk({"commit_delta_", tag}, dlt, r.dlt);
        end
        chk({"hold_ch_", tag}, qch, m_lch[i]);
        chk({"hold_value_", tag}, val, m_lv[i]);
        chk({"hold_delta_", tag}, dlt, m_ld[i]);
        chk({"sticky_", tag}, st, m_sticky[i]);
        chk({"evt_count_", tag}, ev, m_cnt[i]);
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            mon_inst(0, "a", q_a, qch_a, qv_a, qd_a, st_a, ev_a);
            mon_inst(1, "b", q_b, qch_b, qv_b, qd_b, st_b, ev_b);
        end
    end

    initial begin
        int thr, d, rs;
        model_reset();
        repeat (2) @(negedge clk);
        #1 chk_zero("power_on_reset");
        #1 reset = 1'b0;
        mon_en = 1;

        // Build A, threshold 2
        drive(0, 1, 0, 5, 2, 0);
        chk("first_sample_no_q", q_a, 0);
        drive(0, 1, 0, 5, 2, 0);
        chk("second_sample_q", q_a, 1);
        chk("commit_value_5", qv_a, 5);
        chk("commit_delta_5", qd_a, 5);
        chk("sticky_0001", st_a, 1);
        chk("evt_1", ev_a, 1);
        drive(0, 1, 0, 7, 2, 0);
        chk("delta_eq_thr_no_q", q_a, 0);
        drive(0, 1, 0, 9, 2, 0);
        drive(0, 1, 0, 9, 2, 0);
        chk("commit_value_9", qv_a, 9);
        chk("commit_delta_4", qd_a, 4);
        drive(0, 1, 1, 50, 2, 0);
        drive(0, 1, 2, 1, 2, 0);
        drive(0, 1, 1, 60, 2, 0);
        chk("interleave_ch1", qch_a, 1);
        chk("interleave_delta_60", qd_a, 60);
        chk("sticky_0011", st_a, 3);
        drive(0, 1, 3, 200, 2, 0);
        drive(0, 1, 3, 3, 2, 0);
        chk("ch3_value_3", qv_a, 3);
        chk("ch3_delta_3", qd_a, 3);
        drive(0, 1, 0, 100, 2, 0);
        drive(0, 1, 0, 100, 2, 1);
        chk("clear_with_commit_sticky", st_a, 1);
        chk("clear_with_commit_evt", ev_a, 1);
        drive(0, 1, 2, 100, 2, 0);
        do_reset();
        drive(0, 1, 2, 100, 2, 0);
        chk("no_q_after_reset", q_a, 0);
        drive(0, 1, 2, 100, 2, 0);
        chk("ch2_commit_delta_100", qd_a, 100);

        // Build B: CONFIRM=1, saturating 2-bit counter, 3 channels
        drive(1, 1, 0, 10, 0, 0);
        drive(1, 1, 1, 20, 0, 0);
        drive(1, 1, 2, 30, 0, 0);
        drive(1, 1, 0, 11, 0, 0);
        chk("evt_saturates_3", ev_b, 3);
        drive(1, 1, 3, 99, 0, 0);
        chk("out_of_range_no_q", q_b, 0);
        drive(1, 1, 0, 200, 255, 0);
        chk("thr_all_ones_no_q", q_b, 0);
        drive(1, 1, 1, 20, 0, 0);
        chk("zero_delta_no_q", q_b, 0);
        drive(1, 0, 0, 0, 0, 1);
        chk("clear_only_evt", ev_b, 0);

        for (int n = 0; n < 2000; n++) begin
            rs = int'($urandom % 8);
            thr = (rs == 0) ? 0 : (rs == 1) ? 255 : int'($urandom % 12);
            d = ($urandom % 3 == 0) ? int'($urandom % 256) : int'($urandom % 16);
            drive(int'($urandom % 2), ($urandom % 4) != 0, int'($urandom % 4), d, thr,
                  ($urandom % 25) == 0);
            if (n % 700 == 699) do_reset();
        end

        repeat (3) @(negedge clk);
        #1;
        chk("pending_commits_a", qa.size(), 0);
        chk("pending_commits_b", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_delta_monitor.md
SENSOR_DELTA_MONITOR -- requirements
Module: sensor_delta_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 8: sample and stored-value width in bits.
REQ-002 SHALL have parameter CHANNELS, default 4: number of monitored sensor channels (1..16).
REQ-003 SHALL have parameter CONFIRM, default 2: consecutive over-threshold samples needed per channel before commit (1..15).
REQ-004 SHALL have parameter CNTW, default 16: event counter width.
REQ-005 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1: sample strobe; sample accepted on every clk edge where high.
REQ-008 SHALL have port in_ch, input, clog2(CHANNELS) (min 1): channel index of the sample.
REQ-009 SHALL have port in_data, input, WIDTH: sample value.
REQ-010 SHALL have port threshold, input, WIDTH: runtime change threshold, sampled with in_valid.
REQ-011 SHALL have port clear, input, 1: clears sticky flags and event counter.
REQ-012 SHALL have port q, output, 1: one-cycle pulse on committed change.
REQ-013 SHALL have port q_ch, output, clog2(CHANNELS): channel of the last commit.
REQ-014 SHALL have port q_value, output, WIDTH: committed new value.
REQ-015 SHALL have port q_delta, output, WIDTH: absolute difference at commit.
REQ-016 SHALL have port sticky, output, CHANNELS: per-channel changed-since-clear flags.
REQ-017 SHALL have port evt_count, output, CNTW: saturating count of commits since clear.

Function
REQ-018 SHALL keep per channel a stored value (WIDTH) and a confirm counter (4 bits).
REQ-019 On accepted sample, delta SHALL be |in_data - stored[in_ch]| computed unsigned in WIDTH bits, no wrap.
REQ-020 delta > threshold (strict) SHALL increment confirm[in_ch]; delta <= threshold SHALL zero confirm[in_ch], no commit.
REQ-021 When the increment makes confirm[in_ch] equal CONFIRM, SHALL commit: stored[in_ch] <= in_data (latest sample), confirm[in_ch] <= 0.
REQ-022 Commit outputs SHALL be registered: q=1, q_ch, q_value, q_delta valid the cycle after the accepting edge; q low otherwise.
REQ-023 q_ch/q_value/q_delta SHALL hold their last commit values until the next commit.
REQ-024 Samples on other channels SHALL NOT affect a channel's confirm counter (interleaving allowed).
REQ-025 Commit SHALL set sticky[in_ch] and increment evt_count, saturating at all-ones.
REQ-026 clear SHALL zero sticky and evt_count on that edge; a same-edge commit SHALL win (its sticky bit set, evt_count = 1).
REQ-027 in_ch >= CHANNELS SHALL be ignored: no state change, q stays 0.
REQ-028 in_valid low SHALL leave all state unchanged except q returning to 0.
REQ-029 threshold = all-ones SHALL never commit; threshold = 0 SHALL commit any nonzero delta.

Reset
REQ-030 reset high SHALL immediately zero all stored values, confirm counters, sticky, evt_count, q, q_ch, q_value, q_delta.
REQ-031 reset mid-confirm SHALL discard partial counts; no commit pulse after release.

Verification
REQ-032 After reset, threshold=2, ch0 samples 5,5 -> no q after first; q=1, q_ch=0, q_value=5, q_delta=5 after second; sticky=0001, evt_count=1.
REQ-033 Then ch0 sample 7 -> delta 2 not >2, q=0, stored stays 5; then 9,9 -> commit q_value=9, q_delta=4.
REQ-034 ch1 sample 50, ch2 sample 1, ch1 sample 60 -> commit ch1 value 60 delta 60; ch2 no commit; sticky bit1 set.
REQ-035 ch3 sample 200 then 3 (threshold 2) -> confirm resets after 3 (delta 3 >2 counts; verify commit value 3 delta 3); then clear with simultaneous ch0 commit -> sticky=0001, evt_count=1.
REQ-036 ch2 one over-threshold sample, assert reset, release, same sample once -> no q; stored[2]=0 until second sample.
REQ-037 CNTW=2 build, 4 commits -> evt_count saturates at 3.
